// File: rtl/reset_request_gen.sv
// reset_request_gen: debounced button / software / watchdog reset request generator
// Optional watchdog compiled in with macro RESET_REQ_WDT_EN.
module reset_request_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned MIN_ASSERT      = 16,
    parameter int unsigned WDT_CYCLES      = 255
) (
    input  logic       clk,
    input  logic       ext_reset_n,
    input  logic       btn_in,
    input  logic       sw_req,
    input  logic       init_complete,
    output logic       ext_reset,
    output logic       busy,
    output logic       wdt_fault,
    output logic [7:0] reset_count
);
    typedef enum logic [2:0] {IDLE, DEBOUNCE, ASSERT, WAIT_RELEASE, WAIT_INIT} state_t;

    localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(MIN_ASSERT - 1);
    localparam logic [15:0] WDT_LAST  = 16'(WDT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic [15:0] deb_q, deb_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ext_reset_q;
    logic        btn_s;
    logic        enter;
    logic        wdt_exp;
    logic        wdt_hit;

    assign btn_s       = sync_q[1];
    assign ext_reset   = ext_reset_q;
    assign busy        = state_q != IDLE;
    assign reset_count = cnt_q;
    assign cnt_d       = (enter && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;

    // Next state; every counted ASSERT entry funnels through 'enter' so it is counted once
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        hold_d  = 8'd0;
        enter   = 1'b0;
        wdt_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (sw_req) enter = 1'b1;
                else if (btn_s) begin
                    state_d = DEBOUNCE;
                    deb_d   = 16'd1;
                end
            end
            DEBOUNCE: begin
                if (sw_req || (btn_s && deb_q == DEB_LAST)) enter = 1'b1;
                else if (!btn_s) begin
                    state_d = IDLE;
                    deb_d   = 16'd0;
                end
                else deb_d = deb_q + 16'd1;
            end
            ASSERT: begin
                if (hold_q == HOLD_LAST) state_d = btn_s ? WAIT_RELEASE : WAIT_INIT;
                else hold_d = hold_q + 8'd1;
            end
            WAIT_RELEASE: begin
                if (!btn_s) state_d = WAIT_INIT;
            end
            WAIT_INIT: begin
                if (sw_req || btn_s) enter = 1'b1;
                else if (init_complete) state_d = IDLE;
                else if (wdt_exp) begin
                    enter   = 1'b1;
                    wdt_hit = 1'b1;
                end
            end
            default: state_d = ASSERT;
        endcase
        if (enter) begin
            state_d = ASSERT;
            deb_d   = 16'd0;
        end
    end

    // State, synchronizer and counters; reset lands in ASSERT for the power-up pulse
    always_ff @(posedge clk or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            state_q     <= ASSERT;
            sync_q      <= 2'b00;
            deb_q       <= 16'd0;
            hold_q      <= 8'd0;
            cnt_q       <= 8'd0;
            ext_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], btn_in};
            deb_q       <= deb_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            ext_reset_q <= (state_d == ASSERT) || (state_d == WAIT_RELEASE);
        end
    end

`ifdef RESET_REQ_WDT_EN
    logic [15:0] wdt_q, wdt_d;
    logic        wdt_fault_q;

    assign wdt_exp   = wdt_q == WDT_LAST;
    assign wdt_d     = (state_q == WAIT_INIT && state_d == WAIT_INIT) ? wdt_q + 16'd1 : 16'd0;
    assign wdt_fault = wdt_fault_q;

    // Watchdog counts only while staying in WAIT_INIT; the fault flag is sticky
    always_ff @(posedge clk or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            wdt_q       <= 16'd0;
            wdt_fault_q <= 1'b0;
        end else begin
            wdt_q       <= wdt_d;
            wdt_fault_q <= wdt_fault_q | wdt_hit;
        end
    end
`else
    logic unused_wdt;

    assign wdt_exp    = 1'b0;
    assign wdt_fault  = 1'b0;
    assign unused_wdt = ^{WDT_LAST, wdt_hit};
`endif
endmodule

// File: tb/tb_reset_request_gen.sv
// tb_reset_request_gen: scoreboard bench with a countdown-style reference model
module tb_reset_request_gen;
    localparam int DEB = 1000;
    localparam int MIN = 16;
    localparam int WDT = 255;
    localparam bit WDT_EN =
`ifdef RESET_REQ_WDT_EN
        1'b1;
`else
        1'b0;
`endif

    logic       clk = 1'b0;
    logic       ext_reset_n = 1'b0;
    logic       btn_in = 1'b0;
    logic       sw_req = 1'b0;
    logic       init_complete = 1'b0;
    logic       ext_reset, busy, wdt_fault;
    logic [7:0] reset_count;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    reset_request_gen #(.DEBOUNCE_CYCLES(DEB), .MIN_ASSERT(MIN), .WDT_CYCLES(WDT)) dut (
        .clk(clk), .ext_reset_n(ext_reset_n), .btn_in(btn_in), .sw_req(sw_req),
        .init_complete(init_complete), .ext_reset(ext_reset), .busy(busy),
        .wdt_fault(wdt_fault), .reset_count(reset_count)
    );

    typedef enum {M_IDLE, M_QUAL, M_HOLD, M_STUCK, M_WAIT} mode_t;
    mode_t       mode = M_HOLD;
    int          run, hold_left, wdt_left, resets;
    bit          fault;
    bit          bq[$];
    logic [10:0] expq[$];
    logic [10:0] mon_e;

    task automatic model_enter();
        mode = M_HOLD;
        hold_left = MIN;
        if (resets < 255) resets++;
    endtask

    task automatic step(input bit b, input bit sw, input bit ic, input bit rst);
        bit bs;
        @(negedge clk);
        btn_in = b;
        sw_req = sw;
        init_complete = ic;
        ext_reset_n = !rst;
        if (rst) begin
            #1;
            total++;
            if ({ext_reset, busy, wdt_fault, reset_count} != 11'b110_0000_0000) begin
                bad++;
                $display("FAIL async_reset got=%b exp=%b", {ext_reset, busy, wdt_fault, reset_count}, 11'b110_0000_0000);
            end
            mode = M_HOLD;
            hold_left = MIN;
            resets = 0;
            fault = 0;
            run = 0;
            bq = '{1'b0, 1'b0};
        end else begin
            bs = bq.pop_front();
            bq.push_back(b);
            case (mode)
                M_IDLE: if (sw) model_enter(); else if (bs) begin mode = M_QUAL; run = 1; end
                M_QUAL: begin
                    if (sw || (bs && run + 1 >= DEB)) model_enter();
                    else if (!bs) begin mode = M_IDLE; run = 0; end
                    else run++;
                end
                M_HOLD: begin
                    hold_left--;
                    if (hold_left == 0) begin
                        if (bs) mode = M_STUCK;
                        else begin mode = M_WAIT; wdt_left = WDT; end
                    end
                end
                M_STUCK: if (!bs) begin mode = M_WAIT; wdt_left = WDT; end
                M_WAIT: begin
                    if (sw || bs) model_enter();
                    else if (ic) mode = M_IDLE;
                    else if (WDT_EN) begin
                        wdt_left--;
                        if (wdt_left == 0) begin model_enter(); fault = 1; end
                    end
                end
                default: ;
            endcase
        end
        expq.push_back({mode == M_HOLD || mode == M_STUCK, mode != M_IDLE, fault, 8'(resets)});
    endtask

    task automatic wait_er(input bit want, input int lim, input bit b);
        int n = 0;
        while (ext_reset != want && n < lim) begin
            step(b, 0, 0, 0);
            n++;
        end
        total++;
        if (ext_reset != want) begin
            bad++;
            $display("FAIL wait_ext_reset got=%b exp=%b after %0d cycles", ext_reset, want, n);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            total++;
            if ({ext_reset, busy, wdt_fault, reset_count} != mon_e) begin
                bad++;
                $display("FAIL outputs t=%0t got={er,busy,wdt,cnt}=%b exp=%b", $time, {ext_reset, busy, wdt_fault, reset_count}, mon_e);
            end
        end
    end

    initial begin
        int len;
        bit lvl;
        repeat (3) step(0, 0, 0, 1);
        wait_er(0, 40, 0);
        repeat (31) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        repeat (5) step(0, 0, 0, 0);
        repeat (999) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        repeat (2000) step(1, 0, 0, 0);
        wait_er(0, 50, 0);
        step(0, 0, 1, 0);
        repeat (5) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (5) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        wait_er(0, 40, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        wait_er(0, 40, 0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        wait_er(0, 40, 0);
        repeat (300) step(0, 0, 0, 0);
        wait_er(0, 40, 0);
        step(0, 0, 1, 0);
        repeat (100) step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        wait_er(0, 40, 0);
        step(0, 0, 1, 0);
        repeat (40) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 1) ? $urandom_range(1, 20) : $urandom_range(900, 1100);
            repeat (len)
                step(lvl, $urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 1999) == 0);
        end
        step(0, 0, 0, 1);
        repeat (260) begin
            step(0, 1, 0, 0);
            repeat (MIN + 1) step(0, 0, 0, 0);
        end
        @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
